hci_core_r_valid_filter_ot: RTL and testbench
=============================================

// Module: hci_core_r_valid_filter_ot
//
// PURPOSE
// - Multi-outstanding successor of the single-entry HCI r_valid filter: records the wen of every
//   granted request in an in-order tracker and decides per response whether r_valid reaches the slave.
// - Selectable filter mode (all / reads-only / writes-only / none), gating of new requests when the
//   tracker is full, outstanding and dropped-response counters, sticky protocol-error flag.
// - Sits between an HCI core initiator (streamer, accelerator port) and the TCDM interconnect.
//
// PARAMETERS
// - DEPTH     4   max outstanding granted-but-unanswered requests; >=1, power of two
// - CNT_WIDTH 16  width of dropped-response counter
// - DW/AW/BW/UW/... as hci_core_intf defaults; passed through only
//
// PORTS
// - clk_i        in   1          clock; single clock domain
// - rst_i        in   1          synchronous, active-high reset
// - clear_i      in   1          synchronous flush of tracker, counters, error flag
// - enable_i     in   1          1: apply mode_i filtering; 0: r_valid passes unfiltered
// - mode_i       in   2          hci_rvf_mode_t: 00 ALL, 01 READS, 10 WRITES, 11 NONE
// - outstanding_o out $clog2(DEPTH+1) current tracker occupancy
// - dropped_o    out  CNT_WIDTH  count of suppressed r_valid pulses, saturating
// - full_o       out  1          tracker full (requests gated)
// - err_o        out  1          sticky: r_valid received with empty tracker
// - tcdm_slave   hci_core_intf.slave   toward initiator
// - tcdm_master  hci_core_intf.master  toward interconnect
//
// BEHAVIOUR
// - Reset (rst_i=1 at clk edge) and clear_i: pointers=0, outstanding_o=0, dropped_o=0, err_o=0,
//   full_o=0. rst_i has priority over clear_i; both over push/pop in the same cycle.
// - Passthrough: add, data, be, wen, boffs, lrdy, user forward; r_data, r_opc, r_user return, comb.
// - Gating (always active, independent of enable_i): master.req = slave.req & ~full_o;
//   slave.gnt = master.gnt & ~full_o. full_o is registered state (count==DEPTH).
// - Push: master.req & master.gnt -> store slave.wen at wptr, wptr++ (mod DEPTH).
// - Pop: master.r_valid & (count!=0) -> rptr++ (mod DEPTH). Responses arrive in grant order.
// - keep = ALL:1, READS:head_wen, WRITES:~head_wen, NONE:0 (head_wen=1 means read).
// - slave.r_valid = master.r_valid & (enable_i ? keep : 1); zero-cycle comb path.
// - Dropped: r_valid popped with enable_i & ~keep -> dropped_o++, holds at 2^CNT_WIDTH-1.
// - Push+pop same cycle: count unchanged, both pointers advance; legal at any occupancy <DEPTH.
// - Full: no push possible; pop that cycle frees a slot, push allowed next cycle (1-cycle bubble).
// - r_valid in same cycle as its own grant is not supported (min response latency 1 cycle).
// - Empty + r_valid: no pop, r_valid forwarded unfiltered, err_o set until clear_i/rst_i.
// - enable_i / mode_i may change any cycle; tracking continues while disabled so later
//   enabling filters correctly; applied combinationally to current response.
// - Reset or clear mid-operation discards in-flight entries; late responses then raise err_o.
//
// STRUCTURE
// - hci_package: typedef enum logic [1:0] hci_rvf_mode_t {HCI_RVF_ALL, HCI_RVF_READS,
//   HCI_RVF_WRITES, HCI_RVF_NONE}.
// - Sub-module hci_core_r_valid_filter_fifo: 1-bit x DEPTH register FIFO, push/pop/flush,
//   head, count, full, empty outputs; sync active-high reset. Top holds gating, filter, counters.
//
// TESTING
// - DEPTH=4, mode READS, enable=1: grant R,W,R,W, responses 1 cycle later -> slave r_valid on 1st,3rd only; dropped_o=2.
// - Issue 5 reads, gnt=1, no responses -> 4 granted, full_o=1, slave.gnt=0 on 5th; one r_valid -> 5th granted next cycle.
// - Back-to-back push+pop at count=2 for 10 cycles -> outstanding_o stays 2, no drops in mode ALL.
// - r_valid with tracker empty -> slave r_valid=1, err_o=1 held; clear_i -> err_o=0, outstanding_o=0.
// - enable=0 with W,W outstanding, mode NONE -> both r_valid forwarded; enable=1 then W -> dropped, dropped_o=1.
// - CNT_WIDTH=2, 5 dropped writes -> dropped_o saturates at 3; rst_i mid-burst -> all outputs 0 next cycle.

Source files
------------

// File: rtl/hci_package.sv
// Shared types for the HCI r_valid filter: filter mode encoding and the keep decision.
package hci_package;

    typedef enum logic [1:0] {
        HCI_RVF_ALL    = 2'b00,
        HCI_RVF_READS  = 2'b01,
        HCI_RVF_WRITES = 2'b10,
        HCI_RVF_NONE   = 2'b11
    } hci_rvf_mode_t;

    // head_wen = 1 marks a read transaction (HCI wen polarity).
    function automatic logic rvf_keep(input hci_rvf_mode_t mode, input logic head_wen);
        logic keep;
        case (mode)
            HCI_RVF_ALL:    keep = 1'b1;
            HCI_RVF_READS:  keep = head_wen;
            HCI_RVF_WRITES: keep = ~head_wen;
            default:        keep = 1'b0;
        endcase
        return keep;
    endfunction

endpackage

// File: rtl/hci_core_intf.sv
// Minimal HCI core interface carrying the request and response channels used by the filter.
interface hci_core_intf #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 32,
    parameter int unsigned BW = 8,
    parameter int unsigned UW = 1
);
    logic              req;
    logic              gnt;
    logic [AW-1:0]     add;
    logic              wen;
    logic [DW-1:0]     data;
    logic [DW/BW-1:0]  be;
    logic [15:0]       boffs;
    logic              lrdy;
    logic [UW-1:0]     user;
    logic [DW-1:0]     r_data;
    logic              r_valid;
    logic              r_opc;
    logic [UW-1:0]     r_user;

    modport master (
        output req, add, wen, data, be, boffs, lrdy, user,
        input  gnt, r_data, r_valid, r_opc, r_user
    );

    modport slave (
        input  req, add, wen, data, be, boffs, lrdy, user,
        output gnt, r_data, r_valid, r_opc, r_user
    );

endinterface

// File: rtl/hci_core_r_valid_filter_fifo.sv
// In-order tracker of granted request types: 1-bit x DEPTH register FIFO.
module hci_core_r_valid_filter_fifo
    import hci_package::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         data,
    output logic                         head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    // Explicit wrap keeps DEPTH=1 correct where the pointer has spare range.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign do_push = push & (cnt != CW'(DEPTH));
    assign do_pop  = pop & (cnt != '0);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            mem  <= '0;
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= data;
                wptr      <= next_ptr(wptr);
            end
            if (do_pop) begin
                rptr <= next_ptr(rptr);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign head  = mem[rptr];
    assign count = cnt;
    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);

endmodule

// File: rtl/hci_core_r_valid_filter_ot.sv
// Multi-outstanding r_valid filter between an HCI core initiator and the TCDM interconnect.
module hci_core_r_valid_filter_ot
    import hci_package::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clear_i,
    input  logic                         enable_i,
    input  hci_rvf_mode_t                mode_i,
    output logic [$clog2(DEPTH+1)-1:0]   outstanding_o,
    output logic [CNT_WIDTH-1:0]         dropped_o,
    output logic                         full_o,
    output logic                         err_o,
    hci_core_intf.slave                  tcdm_slave,
    hci_core_intf.master                 tcdm_master
);

    logic head_wen;
    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;
    logic keep;
    logic filter_on;
    logic drop;

    logic [CNT_WIDTH-1:0] dropped_q;
    logic                 err_q;

    // Request channel forwards untouched apart from full-gating of req/gnt.
    assign tcdm_master.req   = tcdm_slave.req & ~fifo_full;
    assign tcdm_master.add   = tcdm_slave.add;
    assign tcdm_master.wen   = tcdm_slave.wen;
    assign tcdm_master.data  = tcdm_slave.data;
    assign tcdm_master.be    = tcdm_slave.be;
    assign tcdm_master.boffs = tcdm_slave.boffs;
    assign tcdm_master.lrdy  = tcdm_slave.lrdy;
    assign tcdm_master.user  = tcdm_slave.user;
    assign tcdm_slave.gnt    = tcdm_master.gnt & ~fifo_full;

    assign tcdm_slave.r_data = tcdm_master.r_data;
    assign tcdm_slave.r_opc  = tcdm_master.r_opc;
    assign tcdm_slave.r_user = tcdm_master.r_user;

    assign push = tcdm_slave.req & ~fifo_full & tcdm_master.gnt;
    assign pop  = tcdm_master.r_valid & ~fifo_empty;

    hci_core_r_valid_filter_fifo #(
        .DEPTH (DEPTH)
    ) i_tracker (
        .clk   (clk_i),
        .rst   (rst_i),
        .flush (clear_i),
        .push  (push),
        .pop   (pop),
        .data  (tcdm_slave.wen),
        .head  (head_wen),
        .count (outstanding_o),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // An orphan response (empty tracker) has no type to filter on, so it passes unfiltered.
    assign keep      = rvf_keep(mode_i, head_wen);
    assign filter_on = enable_i & ~fifo_empty;
    assign drop      = pop & enable_i & ~keep;

    assign tcdm_slave.r_valid = tcdm_master.r_valid & (~filter_on | keep);

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            dropped_q <= '0;
        end else if (drop && (dropped_q != '1)) begin
            dropped_q <= dropped_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            err_q <= 1'b0;
        end else if (tcdm_master.r_valid && fifo_empty) begin
            err_q <= 1'b1;
        end
    end

    assign dropped_o = dropped_q;
    assign err_o     = err_q;
    assign full_o    = fifo_full;

endmodule

// File: tb/tb_hci_core_r_valid_filter_ot.sv
// Directed bench for hci_core_r_valid_filter_ot with DEPTH=4 and a 2-bit dropped counter.
module tb_hci_core_r_valid_filter_ot;
    import hci_package::*;

    localparam int unsigned DEPTH     = 4;
    localparam int unsigned CNT_WIDTH = 2;

    logic                       clk;
    logic                       rst;
    logic                       clear;
    logic                       enable;
    hci_rvf_mode_t              mode;
    logic [$clog2(DEPTH+1)-1:0] outstanding;
    logic [CNT_WIDTH-1:0]       dropped;
    logic                       full;
    logic                       err;

    int n_tests;
    int n_failed;

    hci_core_intf slv ();
    hci_core_intf mst ();

    hci_core_r_valid_filter_ot #(
        .DEPTH     (DEPTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .clear_i       (clear),
        .enable_i      (enable),
        .mode_i        (mode),
        .outstanding_o (outstanding),
        .dropped_o     (dropped),
        .full_o        (full),
        .err_o         (err),
        .tcdm_slave    (slv),
        .tcdm_master   (mst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Inputs change 1ns after the rising edge; comb outputs are sampled 1ns later.
    task automatic drive(input logic req, input logic wen, input logic gnt, input logic rv);
        slv.req     = req;
        slv.wen     = wen;
        mst.gnt     = gnt;
        mst.r_valid = rv;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        clear = 1'b0;
    endtask

    initial begin
        n_tests  = 0;
        n_failed = 0;
        rst      = 1'b1;
        clear    = 1'b0;
        enable   = 1'b1;
        mode     = HCI_RVF_ALL;
        slv.req = 1'b0; slv.add = '0; slv.wen = 1'b0; slv.data = '0; slv.be = '0;
        slv.boffs = '0; slv.lrdy = 1'b1; slv.user = '0;
        mst.gnt = 1'b0; mst.r_data = '0; mst.r_valid = 1'b0; mst.r_opc = 1'b0; mst.r_user = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state and passthrough
        check("rst_outstanding", 32'(outstanding), 0);
        check("rst_dropped", 32'(dropped), 0);
        check("rst_full", 32'(full), 0);
        check("rst_err", 32'(err), 0);
        slv.add    = 32'h0000_1234;
        mst.r_data = 32'hdead_beef;
        #1;
        check("pass_add", mst.add, 32'h0000_1234);
        check("pass_r_data", slv.r_data, 32'hdead_beef);

        // READS mode: grant R,W,R,W with 1-cycle response latency
        mode = HCI_RVF_READS;
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        check("t1_mreq", 32'(mst.req), 1);
        check("t1_sgnt", 32'(slv.gnt), 1);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        check("t1_rv0_read", 32'(slv.r_valid), 1);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        check("t1_rv1_write", 32'(slv.r_valid), 0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        check("t1_rv2_read", 32'(slv.r_valid), 1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("t1_rv3_write", 32'(slv.r_valid), 0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("t1_dropped", 32'(dropped), 2);
        check("t1_outstanding", 32'(outstanding), 0);
        check("t1_err", 32'(err), 0);
        do_clear();
        check("t1_clr_dropped", 32'(dropped), 0);

        // Full gating: 5 reads, no responses, then one response frees a slot
        mode = HCI_RVF_ALL;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0);
            check("t2_sgnt_fill", 32'(slv.gnt), 1);
            tick();
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        check("t2_full", 32'(full), 1);
        check("t2_outstanding4", 32'(outstanding), 4);
        check("t2_sgnt_gated", 32'(slv.gnt), 0);
        check("t2_mreq_gated", 32'(mst.req), 0);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        check("t2_rv_full", 32'(slv.r_valid), 1);
        check("t2_sgnt_bubble", 32'(slv.gnt), 0);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        check("t2_full_freed", 32'(full), 0);
        check("t2_outstanding3", 32'(outstanding), 3);
        check("t2_sgnt_fifth", 32'(slv.gnt), 1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("t2_refull", 32'(full), 1);
        check("t2_outstanding_re4", 32'(outstanding), 4);
        do_clear();

        // Back-to-back push+pop at occupancy 2
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        check("t3_start2", 32'(outstanding), 2);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'(i % 2), 1'b1, 1'b1);
            check("t3_rv", 32'(slv.r_valid), 1);
            tick();
            check("t3_outstanding", 32'(outstanding), 2);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("t3_dropped", 32'(dropped), 0);
        do_clear();

        // Orphan response with empty tracker; clear has priority over a concurrent push
        mode = HCI_RVF_NONE;
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("t4_rv_orphan", 32'(slv.r_valid), 1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("t4_err_set", 32'(err), 1);
        check("t4_outstanding", 32'(outstanding), 0);
        tick();
        check("t4_err_held", 32'(err), 1);
        clear = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        clear = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("t4_err_clr", 32'(err), 0);
        check("t4_clr_over_push", 32'(outstanding), 0);

        // Disabled filtering still tracks; enabling applies NONE to the next write
        enable = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        check("t5_outstanding2", 32'(outstanding), 2);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("t5_rv_dis0", 32'(slv.r_valid), 1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("t5_rv_dis1", 32'(slv.r_valid), 1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("t5_dropped0", 32'(dropped), 0);
        check("t5_outstanding0", 32'(outstanding), 0);
        enable = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("t5_rv_en", 32'(slv.r_valid), 0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("t5_dropped1", 32'(dropped), 1);
        check("t5_err", 32'(err), 0);
        do_clear();

        // Saturation of the 2-bit dropped counter, then reset mid-burst
        mode = HCI_RVF_READS;
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        check("t6_err_pre", 32'(err), 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b1);
            check("t6_rv_drop", 32'(slv.r_valid), 0);
            tick();
        end
        check("t6_dropped_sat4", 32'(dropped), 3);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("t6_dropped_sat5", 32'(dropped), 3);
        check("t6_outstanding0", 32'(outstanding), 0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0);
            tick();
        end
        check("t6_full", 32'(full), 1);
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("t6_rst_outstanding", 32'(outstanding), 0);
        check("t6_rst_dropped", 32'(dropped), 0);
        check("t6_rst_full", 32'(full), 0);
        check("t6_rst_err", 32'(err), 0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("t6_late_rv", 32'(slv.r_valid), 1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("t6_late_err", 32'(err), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
